// File: rtl/calc_pkg.sv
// Shared calculator definitions: operator and key encodings, parser state type,
// and the operator selection/toggling helpers used by the keypad parser.
package calc_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_MOD = 3'd4;
  localparam logic [2:0] OP_EQ  = 3'd5;
  localparam logic [2:0] OP_CLR = 3'd6;

  // Codes 0x0..0x9 are decimal digits.
  localparam logic [3:0] KEY_9      = 4'h9;
  localparam logic [3:0] KEY_DIVMOD = 4'hA;
  localparam logic [3:0] KEY_MUL    = 4'hB;
  localparam logic [3:0] KEY_ADDSUB = 4'hC;
  localparam logic [3:0] KEY_AC     = 4'hD;
  localparam logic [3:0] KEY_ANS    = 4'hE;
  localparam logic [3:0] KEY_EQ     = 4'hF;

  typedef enum logic [1:0] {
    ST_START,
    ST_NUM,
    ST_OP
  } state_t;

  function automatic logic [2:0] base_op(input logic [3:0] key);
    logic [2:0] op;
    case (key)
      KEY_DIVMOD: op = OP_DIV;
      KEY_MUL:    op = OP_MUL;
      default:    op = OP_ADD;
    endcase
    return op;
  endfunction

  // Repeating +- or /% flips between the pair; any other key selects its base op.
  function automatic logic [2:0] next_op(input logic [2:0] pend, input logic [3:0] key);
    logic [2:0] op;
    op = base_op(key);
    if (key == KEY_ADDSUB && pend == OP_ADD) op = OP_SUB;
    if (key == KEY_ADDSUB && pend == OP_SUB) op = OP_ADD;
    if (key == KEY_DIVMOD && pend == OP_DIV) op = OP_MOD;
    if (key == KEY_DIVMOD && pend == OP_MOD) op = OP_DIV;
    return op;
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Four-entry circular buffer of 4-bit key codes; push while full is only legal
// together with a pop on the same edge.
module key_fifo (
  input  logic       sw_clk,
  input  logic       rst,
  input  logic       push,
  input  logic [3:0] din,
  input  logic       pop,
  output logic [3:0] dout,
  output logic       full,
  output logic       empty
);

  logic [3:0] mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;

  assign full  = (count == 3'd4);
  assign empty = (count == 3'd0);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge sw_clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge sw_clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/keypad_token_parser.sv
// Turns keypad strobes into operand/operator tokens for the calculator ALU.
// Define KEY_FIFO_EN to buffer strobes in a 4-deep key FIFO instead of dropping them.
module keypad_token_parser
  import calc_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int MAX_DIGITS = 8
) (
  input  logic             sw_clk,
  input  logic             rst,
  input  logic [4:0]       eBCD,
  input  logic [WIDTH-1:0] ans_value,
  output logic             tok_valid,
  input  logic             tok_ready,
  output logic [WIDTH-1:0] tok_operand,
  output logic [2:0]       tok_op,
  output logic [WIDTH-1:0] entry_value,
  output logic [3:0]       entry_digits,
  output logic [2:0]       op_pending,
  output logic             key_drop
);

  localparam logic signed [WIDTH-1:0] TEN     = WIDTH'(10);
  localparam logic [3:0]              MAX_DIG = 4'(MAX_DIGITS);

  state_t                  state_q, state_d;
  logic signed [WIDTH-1:0] entry_q, entry_d;
  logic [3:0]              digits_q, digits_d;
  logic                    locked_q, locked_d;
  logic [2:0]              pend_q, pend_d;

  logic                    slot_free;
  logic                    key_vld;
  logic [3:0]              key_code;
  logic                    drop_now;
  logic signed [WIDTH-1:0] digit;

  logic                    emit;
  logic signed [WIDTH-1:0] emit_operand;
  logic [2:0]              emit_op;

  assign slot_free = !tok_valid || tok_ready;

`ifdef KEY_FIFO_EN
  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [3:0] fifo_dout;

  assign fifo_pop  = !fifo_empty && slot_free;
  assign fifo_push = eBCD[4] && (!fifo_full || fifo_pop);
  assign drop_now  = eBCD[4] && fifo_full && !fifo_pop;
  assign key_vld   = fifo_pop;
  assign key_code  = fifo_dout;

  key_fifo u_key_fifo (
    .sw_clk (sw_clk),
    .rst    (rst),
    .push   (fifo_push),
    .din    (eBCD[3:0]),
    .pop    (fifo_pop),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );
`else
  assign key_vld  = eBCD[4] && slot_free;
  assign key_code = eBCD[3:0];
  assign drop_now = eBCD[4] && !slot_free;
`endif

  assign digit = $signed({{(WIDTH-4){1'b0}}, key_code});

  always_comb begin
    state_d      = state_q;
    entry_d      = entry_q;
    digits_d     = digits_q;
    locked_d     = locked_q;
    pend_d       = pend_q;
    emit         = 1'b0;
    emit_operand = '0;
    emit_op      = OP_ADD;
    if (key_vld) begin
      if (key_code <= KEY_9) begin
        case (state_q)
          ST_START: begin
            entry_d  = digit;
            digits_d = 4'd1;
            locked_d = 1'b0;
            state_d  = ST_NUM;
          end
          ST_NUM: begin
            // Extra digits and digits after an ans load are silently ignored.
            if (digits_q < MAX_DIG && !locked_q) begin
              entry_d  = entry_q * TEN + digit;
              digits_d = digits_q + 4'd1;
            end
          end
          default: begin
            emit         = 1'b1;
            emit_operand = entry_q;
            emit_op      = pend_q;
            entry_d      = digit;
            digits_d     = 4'd1;
            locked_d     = 1'b0;
            state_d      = ST_NUM;
          end
        endcase
      end else begin
        case (key_code)
          KEY_DIVMOD, KEY_MUL, KEY_ADDSUB: begin
            if (state_q == ST_OP) begin
              pend_d = next_op(pend_q, key_code);
            end else begin
              // An operator on an empty entry chains on the previous result.
              if (state_q == ST_START) begin
                entry_d  = $signed(ans_value);
                locked_d = 1'b1;
                digits_d = 4'd0;
              end
              pend_d  = base_op(key_code);
              state_d = ST_OP;
            end
          end
          KEY_ANS: begin
            if (state_q == ST_OP) begin
              emit         = 1'b1;
              emit_operand = entry_q;
              emit_op      = pend_q;
            end
            entry_d  = $signed(ans_value);
            locked_d = 1'b1;
            digits_d = 4'd0;
            state_d  = ST_NUM;
          end
          KEY_EQ: begin
            emit         = 1'b1;
            emit_operand = (state_q == ST_START) ? '0 : entry_q;
            emit_op      = OP_EQ;
            entry_d      = '0;
            digits_d     = 4'd0;
            locked_d     = 1'b0;
            pend_d       = OP_ADD;
            state_d      = ST_START;
          end
          default: begin
            emit     = 1'b1;
            emit_op  = OP_CLR;
            entry_d  = '0;
            digits_d = 4'd0;
            locked_d = 1'b0;
            pend_d   = OP_ADD;
            state_d  = ST_START;
          end
        endcase
      end
    end
  end

  always_ff @(posedge sw_clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_START;
      entry_q  <= '0;
      digits_q <= 4'd0;
      locked_q <= 1'b0;
      pend_q   <= OP_ADD;
    end else begin
      state_q  <= state_d;
      entry_q  <= entry_d;
      digits_q <= digits_d;
      locked_q <= locked_d;
      pend_q   <= pend_d;
    end
  end

  // Token slot: a new token may replace one being accepted on the same edge.
  always_ff @(posedge sw_clk or negedge rst) begin
    if (!rst) begin
      tok_valid   <= 1'b0;
      tok_operand <= '0;
      tok_op      <= OP_ADD;
      key_drop    <= 1'b0;
    end else begin
      key_drop <= drop_now;
      if (emit) begin
        tok_valid   <= 1'b1;
        tok_operand <= emit_operand;
        tok_op      <= emit_op;
      end else if (tok_ready) begin
        tok_valid <= 1'b0;
      end
    end
  end

  assign entry_value  = entry_q;
  assign entry_digits = digits_q;
  assign op_pending   = (state_q == ST_OP) ? pend_q : 3'd0;

endmodule

// File: tb/tb_keypad_token_parser.sv
// Self-checking bench for keypad_token_parser: directed scenarios plus random keys
// compared every cycle against a queue-based behavioural calculator-entry model.
`timescale 1ns/1ps
module tb_keypad_token_parser;

  localparam int W    = 32;
  localparam int MAXD = 8;
  localparam int ADD = 0, SUB = 1, MUL = 2, DIV = 3, MOD = 4, EQ = 5, CLR = 6;
  localparam int P_EMPTY = 0, P_NUM = 1, P_OP = 2;

  logic         sw_clk = 1'b0;
  logic         rst;
  logic [4:0]   eBCD;
  logic [W-1:0] ans_value;
  logic         tok_valid;
  logic         tok_ready;
  logic [W-1:0] tok_operand;
  logic [2:0]   tok_op;
  logic [W-1:0] entry_value;
  logic [3:0]   entry_digits;
  logic [2:0]   op_pending;
  logic         key_drop;

  keypad_token_parser #(.WIDTH(W), .MAX_DIGITS(MAXD)) dut (
    .sw_clk       (sw_clk),
    .rst          (rst),
    .eBCD         (eBCD),
    .ans_value    (ans_value),
    .tok_valid    (tok_valid),
    .tok_ready    (tok_ready),
    .tok_operand  (tok_operand),
    .tok_op       (tok_op),
    .entry_value  (entry_value),
    .entry_digits (entry_digits),
    .op_pending   (op_pending),
    .key_drop     (key_drop)
  );

  always #5 sw_clk = ~sw_clk;

  int  total = 0;
  int  bad   = 0;
  int  drops = 0;
  bit  chk_en = 0;
  bit  rdy = 0;
  logic [W-1:0] ans_next = '0;

  // Model: the calculator entry as a plain number plus a phase.
  longint     m_entry;
  int         m_digits;
  bit         m_locked;
  int         m_phase;
  int         m_pend;
  bit         m_tv;
  longint     m_top;
  int         m_top_op;
  bit         m_drop;
  logic [3:0] m_q[$];

  longint log_val[$];
  int     log_op[$];

  task automatic chk(string name, longint act, longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_tok(string name, int idx, longint val, int op);
    if (idx < log_val.size()) begin
      chk({name, "_operand"}, log_val[idx], val);
      chk({name, "_op"}, longint'(log_op[idx]), longint'(op));
    end else begin
      chk({name, "_present"}, longint'(log_val.size()), longint'(idx + 1));
    end
  endtask

  task automatic m_emit(longint v, int op);
    m_tv = 1; m_top = v; m_top_op = op;
  endtask

  task automatic m_clear();
    m_entry = 0; m_digits = 0; m_locked = 0; m_pend = 0; m_phase = P_EMPTY;
  endtask

  task automatic model_reset();
    m_clear();
    m_tv = 0; m_top = 0; m_top_op = 0; m_drop = 0;
    m_q.delete();
  endtask

  task automatic apply_key(int k);
    longint ans;
    ans = longint'($signed(ans_value));
    if (k <= 9) begin
      if (m_phase == P_NUM) begin
        if (m_digits < MAXD && !m_locked) begin
          m_entry = m_entry * 10 + k;
          m_digits++;
        end
      end else begin
        if (m_phase == P_OP) m_emit(m_entry, m_pend);
        m_entry = k; m_digits = 1; m_locked = 0; m_phase = P_NUM;
      end
    end else if (k >= 10 && k <= 12) begin
      int base;
      base = (k == 10) ? DIV : (k == 11) ? MUL : ADD;
      if (m_phase == P_OP) begin
        if (k == 12 && (m_pend == ADD || m_pend == SUB)) m_pend = ADD + SUB - m_pend;
        else if (k == 10 && (m_pend == DIV || m_pend == MOD)) m_pend = DIV + MOD - m_pend;
        else m_pend = base;
      end else begin
        if (m_phase == P_EMPTY) begin
          m_entry = ans; m_locked = 1; m_digits = 0;
        end
        m_pend = base; m_phase = P_OP;
      end
    end else if (k == 13) begin
      m_emit(0, CLR); m_clear();
    end else if (k == 14) begin
      if (m_phase == P_OP) m_emit(m_entry, m_pend);
      m_entry = ans; m_locked = 1; m_digits = 0; m_phase = P_NUM;
    end else begin
      m_emit((m_phase == P_EMPTY) ? 0 : m_entry, EQ); m_clear();
    end
  endtask

  // Predicts the state after the coming clock edge from the inputs now applied.
  task automatic model_step();
    bit slot_free;
    bit nxt_drop;
    int k;
    bit kv;
    if (!rst) begin model_reset(); return; end
    slot_free = !m_tv || tok_ready;
    nxt_drop = 0; kv = 0; k = 0;
`ifdef KEY_FIFO_EN
    if (m_q.size() > 0 && slot_free) begin kv = 1; k = int'(m_q.pop_front()); end
    if (eBCD[4]) begin
      if (m_q.size() < 4) m_q.push_back(eBCD[3:0]);
      else nxt_drop = 1;
    end
`else
    if (eBCD[4]) begin
      if (slot_free) begin kv = 1; k = int'(eBCD[3:0]); end
      else nxt_drop = 1;
    end
`endif
    if (m_tv && tok_ready) m_tv = 0;
    if (kv) apply_key(k);
    m_drop = nxt_drop;
  endtask

  task automatic drive(bit stb, logic [3:0] code);
    @(negedge sw_clk); #1;
    eBCD = {stb, code};
    tok_ready = rdy;
    ans_value = ans_next;
    if (tok_valid && tok_ready) begin
      log_val.push_back(longint'($signed(tok_operand)));
      log_op.push_back(int'(tok_op));
    end
    model_step();
  endtask

  task automatic press(logic [3:0] code);
    drive(1'b1, code);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'h0);
  endtask

  task automatic clear_log();
    log_val.delete(); log_op.delete();
  endtask

  task automatic do_reset(bit check_async);
    @(negedge sw_clk); #1;
    rst = 1'b0; eBCD = '0;
    #1;
    if (check_async) chk("async_reset_tok_valid", longint'(tok_valid), 0);
    model_reset();
    @(negedge sw_clk); #1;
    rst = 1'b1;
    model_step();
  endtask

  always @(negedge sw_clk) begin
    if (chk_en) begin
      if (key_drop) drops++;
      chk("tok_valid", longint'(tok_valid), longint'(m_tv));
      if (m_tv) begin
        chk("tok_operand", longint'($signed(tok_operand)), m_top);
        chk("tok_op", longint'(tok_op), longint'(m_top_op));
      end
      chk("entry_value", longint'($signed(entry_value)), m_entry);
      chk("entry_digits", longint'(entry_digits), longint'(m_digits));
      chk("op_pending", longint'(op_pending), longint'((m_phase == P_OP) ? m_pend : 0));
      chk("key_drop", longint'(key_drop), longint'(m_drop));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [3:0] code;
    rst = 1'b0; eBCD = '0; tok_ready = 1'b0; ans_value = '0;
    model_reset();
    repeat (2) @(negedge sw_clk);
    chk("rst_tok_valid", longint'(tok_valid), 0);
    chk("rst_tok_operand", longint'(tok_operand), 0);
    chk("rst_tok_op", longint'(tok_op), 0);
    chk("rst_entry_value", longint'(entry_value), 0);
    chk("rst_entry_digits", longint'(entry_digits), 0);
    chk("rst_op_pending", longint'(op_pending), 0);
    chk("rst_key_drop", longint'(key_drop), 0);
    #1; rst = 1'b1; chk_en = 1;

    // 1,2,3,+,4,= with the ALU always ready
    rdy = 1; clear_log();
    press(4'h1); press(4'h2); press(4'h3); press(4'hC); press(4'h4); press(4'hF);
    idle(4);
    chk("t1_count", longint'(log_val.size()), 2);
    chk_tok("t1_tok0", 0, 123, ADD);
    chk_tok("t1_tok1", 1, 4, EQ);
    chk("t1_entry", longint'($signed(entry_value)), 0);

    // operator toggling
    clear_log();
    press(4'h7); press(4'hC); press(4'hC); press(4'h2); press(4'hF); idle(3);
    chk_tok("t2_sub", 0, 7, SUB);
    clear_log();
    press(4'h7); press(4'hA); press(4'hA); press(4'hA); press(4'h2); press(4'hF); idle(3);
    chk_tok("t2_div", 0, 7, DIV);
    clear_log();
    press(4'h7); press(4'hA); press(4'hB); press(4'h2); press(4'hF); idle(3);
    chk_tok("t2_mul", 0, 7, MUL);

    // digit limit
    clear_log(); drops = 0;
    for (int i = 0; i < 9; i++) press(4'h1);
    idle(3);
    chk("t3_entry", longint'($signed(entry_value)), 11111111);
    chk("t3_digits", longint'(entry_digits), 8);
    chk("t3_no_token", longint'(log_val.size()), 0);
    chk("t3_no_drop", longint'(drops), 0);
    press(4'hD); idle(3);

    // busy output slot
    rdy = 0; clear_log(); drops = 0;
    press(4'h5); press(4'hC); press(4'h6); press(4'hF); press(4'hD);
    idle(2);
    chk("t4_entry", longint'($signed(entry_value)), 6);
    chk("t4_digits", longint'(entry_digits), 1);
    rdy = 1; idle(6);
    chk_tok("t4_tok0", 0, 5, ADD);
`ifdef KEY_FIFO_EN
    chk("t4_drops", longint'(drops), 0);
    chk_tok("t4_tok1", 1, 6, EQ);
    chk_tok("t4_tok2", 2, 0, CLR);
`else
    chk("t4_drops", longint'(drops), 2);
    chk("t4_count", longint'(log_val.size()), 1);
`endif

    // AC mid-expression, then reset with a token waiting
    press(4'hD); idle(3); clear_log();
    press(4'h5); press(4'hC); press(4'hD); idle(3);
    chk_tok("t5_clr", 0, 0, CLR);
    chk("t5_op_pending", longint'(op_pending), 0);
    rdy = 0;
    press(4'h5); press(4'hF); idle(2);
    chk("t5_tok_held", longint'(tok_valid), 1);
    do_reset(1'b1);
    rdy = 1; idle(2);

    // chaining on ans_value
    ans_next = W'(-42);
    press(4'hF); idle(2); clear_log();
    press(4'hB); press(4'h3); press(4'hF); idle(3);
    chk_tok("t6_tok0", 0, -42, MUL);
    chk_tok("t6_tok1", 1, 3, EQ);
    press(4'hE); press(4'h9); idle(3);
    chk("t6_entry", longint'($signed(entry_value)), -42);
    chk("t6_count", longint'(log_val.size()), 2);
    press(4'hD); idle(3);

    // randomized traffic with intermittent back-pressure
    for (int i = 0; i < 4000; i++) begin
      if (i % 37 == 0) begin
        if ($urandom_range(0, 1) == 0) ans_next = W'($urandom);
        else ans_next = W'(0) - W'($urandom_range(0, 500));
      end
      if (i % 200 < 40) rdy = ($urandom_range(0, 7) == 0);
      else rdy = ($urandom_range(0, 3) != 0);
      r = int'($urandom_range(0, 99));
      if (r < 55)      code = 4'($urandom_range(0, 9));
      else if (r < 65) code = 4'hA;
      else if (r < 72) code = 4'hB;
      else if (r < 80) code = 4'hC;
      else if (r < 87) code = 4'hE;
      else if (r < 97) code = 4'hF;
      else             code = 4'hD;
      drive($urandom_range(0, 99) < 60, code);
      if (i == 2500) do_reset(1'b0);
    end
    rdy = 1; idle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_token_parser.md
# keypad_token_parser

Consumes the one-cycle `eBCD` key strobes from the keypad driver and turns them into operand/operator tokens for the calculator ALU. It accumulates decimal digits into a binary operand, tracks the pending operator with +/- and /% toggling, and inserts the previous result (`ans`). It emits tokens over a valid/ready handshake and exports the live entry value to the display path.

## Interface
- `WIDTH`, 32: signed operand width.
- `MAX_DIGITS`, 8: maximum decimal digits per typed operand. Must satisfy 10^MAX_DIGITS − 1 < 2^(WIDTH−1).
- `sw_clk`  in  1  system clock, all logic on posedge.
- `rst`  in  1  asynchronous, active-low reset.
- `eBCD`  in  5  key code. Bit 4 is the one-cycle valid strobe. Bits 3:0 encode: 0–9 digit, a `/%`, b `*`, c `+-`, d AC, e ans, f `=`.
- `ans_value`  in  WIDTH  last ALU result (signed). Sampled when used.
- `tok_valid`  out  1  token available.
- `tok_ready`  in  1  ALU accepts token.
- `tok_operand`  out  WIDTH  signed operand carried by token.
- `tok_op`  out  3  operator terminating the operand: ADD 0, SUB 1, MUL 2, DIV 3, MOD 4, EQ 5, CLR 6.
- `entry_value`  out  WIDTH  operand currently held, for display.
- `entry_digits`  out  4  digits typed into current entry.
- `op_pending`  out  3  pending operator, valid in ST_OP; otherwise 0.
- `key_drop`  out  1  one-cycle pulse when a key is discarded.

## Operation
- A key is accepted on a posedge with `eBCD[4]`=1.
- Acceptance requires a free output slot: `!tok_valid || tok_ready` on the same edge.
- States:
  - ST_START: empty entry.
  - ST_NUM: typing or ans-loaded.
  - ST_OP: operand frozen, operator pending.
- Digit:
  - ST_START: entry := d, digits := 1, go to ST_NUM.
  - ST_NUM: if digits < MAX_DIGITS and not `locked`, entry := entry·10 + d and digits++. Otherwise ignore the digit (no drop pulse).
  - ST_OP: emit {entry, pending}, entry := d, digits := 1, go to ST_NUM.
- Operator key (`a`, `b`, `c`):
  - ST_NUM: pending := DIV, MUL or ADD respectively; go to ST_OP. No token.
  - ST_OP, same key: `c` toggles ADD↔SUB; `a` toggles DIV↔MOD; `b` is unchanged.
  - ST_OP, different key: replaces pending with that key's base operator.
  - ST_START: entry := `ans_value`, then behave as in ST_NUM (chain on result).
- `ans`:
  - ST_START or ST_NUM: entry := `ans_value`, `locked` := 1, go to ST_NUM.
  - ST_OP: emit {entry, pending}, then load `ans_value` as above.
- `=`:
  - ST_NUM or ST_OP: emit {entry, EQ} (a pending op is discarded), clear entry, go to ST_START.
  - ST_START: emit {0, EQ}.
- AC: from any state, emit {0, CLR}, clear entry, digits, `locked` and pending, go to ST_START.
- Typed digits are non-negative magnitudes. Sign enters only via `ans_value`.
- Output token register holds until `tok_valid && tok_ready`. A new token may load on the same edge the old one is accepted.

## Timing
- Reset values:
  - `tok_valid`=0, `tok_operand`=0, `tok_op`=0
  - `entry_value`=0, `entry_digits`=0, `op_pending`=0, `key_drop`=0
  - state ST_START, `locked`=0
- Reset is asynchronous mid-operation. It discards any pending token and any queued keys.
- Latency without FIFO: key strobe on edge N; `entry_*` and `tok_*` are updated after edge N.
- `key_drop` is high for the cycle after a discarded strobe.
- Simultaneous accept and emit: `tok_valid` stays 1 and carries the new token.
- `entry_value`·10 never overflows, given the `MAX_DIGITS` constraint.

## Configuration
- `KEY_FIFO_EN` defined:
  - Strobes are pushed into a 4-entry FIFO. The parser pops only when the output slot is free.
  - Latency is +1 cycle.
  - `key_drop` pulses only when a key arrives while the FIFO is full. A simultaneous push and pop on a full FIFO is allowed.
- `KEY_FIFO_EN` undefined:
  - A strobe arriving while the slot is busy is discarded and pulses `key_drop`.
  - This applies to every key, including digits.

## Structure
- Shared package `calc_pkg`:
  - operator encodings ADD..CLR
  - key code constants 0x0–0xF
  - state enum
  - default `WIDTH`
- Sub-module `key_fifo`:
  - 4×4-bit circular buffer with 2-bit pointers and wrap-around.
  - Full/empty flags.
  - Instantiated only under `KEY_FIFO_EN`.

## Test plan
- Keys 1,2,3,c,4,f with `tok_ready`=1 → token {123,ADD} after key 4, then {4,EQ}; `entry_value` 0 at end.
- Keys 7,c,c,2 → token {7,SUB}; keys 7,a,a,a,2 → {7,DIV}; keys 7,a,b,2 → {7,MUL}.
- Nine `1` keys, `MAX_DIGITS`=8 → `entry_value`=11111111, `entry_digits`=8, no token, no drop.
- `tok_ready`=0 with a token pending, then keys f,d:
  - Without `KEY_FIFO_EN`: two `key_drop` pulses, state unchanged.
  - With it: after `tok_ready`=1, tokens {x,EQ} then {0,CLR} in order.
- Keys 5,c,d → {0,CLR}, state ST_START; reset asserted mid-token → `tok_valid` 0 immediately.
- After `=`, with `ans_value`=−42, keys b,3 → token {−42,MUL}; key e then digit 9 → 9 ignored, `entry_value`=−42.
